// File: rtl/sm_mac_pipe.sv
// sm_mac_pipe: two-stage sign-magnitude multiply-accumulate.
// S1 registers the magnitude product and effective sign. S2 folds each
// product into the accumulator. Negative terms are added in ones'-complement
// form, and the deferred +1 corrections are summed when the last beat retires.
// Optional feature macro: SM_MAC_ZERO_SKIP_EN. When it is defined, zero-product
// beats do not clock the accumulator, and the skip_cnt output reports them.
module sm_mac_pipe #(
  parameter int W     = 4,
  parameter int ACC_W = 16,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     in_a,
  input  logic [W-1:0]     in_b,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_result,
`ifdef SM_MAC_ZERO_SKIP_EN
  output logic [CNT_W-1:0] skip_cnt,
`endif
  output logic [CNT_W-1:0] out_cnt
);

  localparam int MW = 2 * (W - 1);

  logic             stall;
  logic [MW-1:0]    mag_c;

  logic             s1_valid;
  logic             s1_last;
  logic             s1_sgn;
  logic [MW-1:0]    s1_mag;

  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] neg;
  logic [CNT_W-1:0] cnt;

  logic [ACC_W-1:0] term;
  logic [ACC_W-1:0] acc_next;
  logic [ACC_W-1:0] neg_next;
  logic [CNT_W-1:0] cnt_next;

`ifdef SM_MAC_ZERO_SKIP_EN
  logic             s1_zero;
  logic [CNT_W-1:0] skip;
  logic [CNT_W-1:0] skip_next;
`endif

  assign stall    = out_valid & ~out_ready;
  assign in_ready = ~stall;
  assign mag_c    = MW'(in_a[W-2:0]) * MW'(in_b[W-2:0]);

  // S1: capture the magnitude product and sign. A zero product never carries a sign.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_last  <= 1'b0;
      s1_sgn   <= 1'b0;
      s1_mag   <= '0;
`ifdef SM_MAC_ZERO_SKIP_EN
      s1_zero  <= 1'b0;
`endif
    end else if (!stall) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_last <= in_last;
        s1_mag  <= mag_c;
        s1_sgn  <= (in_a[W-1] ^ in_b[W-1]) & (mag_c != '0);
`ifdef SM_MAC_ZERO_SKIP_EN
        s1_zero <= (in_a[W-2:0] == '0) || (in_b[W-2:0] == '0);
`endif
      end
    end
  end

  // S2 next-state arithmetic: ones'-complement term plus deferred-correction count.
  always_comb begin
    term     = s1_sgn ? ~(ACC_W'(s1_mag)) : ACC_W'(s1_mag);
    acc_next = acc + term;
    neg_next = neg + ACC_W'(s1_sgn);
    cnt_next = cnt + CNT_W'(1);
`ifdef SM_MAC_ZERO_SKIP_EN
    skip_next = skip + CNT_W'(s1_zero);
    if (s1_zero) acc_next = acc;
`endif
  end

  // S2: accumulate the group; clear on the last beat so the next group starts clean.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= '0;
      neg <= '0;
      cnt <= '0;
`ifdef SM_MAC_ZERO_SKIP_EN
      skip <= '0;
`endif
    end else if (!stall && s1_valid) begin
      if (s1_last) begin
        acc <= '0;
        neg <= '0;
        cnt <= '0;
`ifdef SM_MAC_ZERO_SKIP_EN
        skip <= '0;
`endif
      end else begin
`ifdef SM_MAC_ZERO_SKIP_EN
        if (!s1_zero) acc <= acc_next;
        skip <= skip_next;
`else
        acc <= acc_next;
`endif
        neg <= neg_next;
        cnt <= cnt_next;
      end
    end
  end

  // Output register: load on a retiring last beat, otherwise drop after the handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid  <= 1'b0;
      out_result <= '0;
      out_cnt    <= '0;
`ifdef SM_MAC_ZERO_SKIP_EN
      skip_cnt   <= '0;
`endif
    end else if (!stall) begin
      if (s1_valid && s1_last) begin
        out_valid  <= 1'b1;
        out_result <= acc_next + neg_next;
        out_cnt    <= cnt_next;
`ifdef SM_MAC_ZERO_SKIP_EN
        skip_cnt   <= skip_next;
`endif
      end else if (out_valid) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_sm_mac_pipe.sv
// tb_sm_mac_pipe: scoreboard bench for sm_mac_pipe. Expected group results
// are computed as signed integer dot products and are queued when each last
// beat is accepted. A monitor pops one entry per output handshake.
module tb_sm_mac_pipe;

  localparam int W     = 4;
  localparam int ACC_W = 16;
  localparam int CNT_W = 8;

  typedef struct packed {
    logic [ACC_W-1:0] r;
    logic [CNT_W-1:0] c;
    logic [CNT_W-1:0] s;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [W-1:0]     in_a;
  logic [W-1:0]     in_b;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] out_result;
  logic [CNT_W-1:0] out_cnt;
`ifdef SM_MAC_ZERO_SKIP_EN
  logic [CNT_W-1:0] skip_cnt;
`endif

  int   checks   = 0;
  int   failures = 0;
  exp_t q[$];
  int   g_sum = 0;
  int   g_cnt = 0;
  int   g_skip = 0;
  bit   rand_ready = 1'b0;
  bit   fixed_ready = 1'b1;

  sm_mac_pipe #(.W(W), .ACC_W(ACC_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result),
`ifdef SM_MAC_ZERO_SKIP_EN
    .skip_cnt(skip_cnt),
`endif
    .out_cnt(out_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog expired actual=running required=finished");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Reference: signed value of a sign-magnitude operand.
  function automatic int sm_val(input logic [W-1:0] v);
    int m;
    m = int'(v[W-2:0]);
    return v[W-1] ? -m : m;
  endfunction

  task automatic model_accept(input logic [W-1:0] a, input logic [W-1:0] b, input logic l);
    exp_t e;
    g_sum += sm_val(a) * sm_val(b);
    g_cnt++;
    if (a[W-2:0] == 0 || b[W-2:0] == 0) g_skip++;
    if (l) begin
      e.r = g_sum[ACC_W-1:0];
      e.c = g_cnt[CNT_W-1:0];
      e.s = g_skip[CNT_W-1:0];
      q.push_back(e);
      g_sum = 0; g_cnt = 0; g_skip = 0;
    end
  endtask

  // Advance to the next falling edge and choose out_ready for the coming rising edge.
  task automatic tick();
    @(negedge clk);
    out_ready = rand_ready ? ($urandom_range(0, 3) != 0) : fixed_ready;
    #1;
  endtask

  // Present a beat and hold it until the DUT is ready. Returns after the accepting edge.
  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic l);
    int n;
    in_a = a; in_b = b; in_last = l; in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 200) begin
      tick();
      n++;
    end
    if (n >= 200) begin
      checks++; failures++;
      $display("FAIL send_timeout actual=in_ready_low required=accept");
    end
    model_accept(a, b, l);
    tick();
  endtask

  task automatic idle();
    in_valid = 1'b0;
    tick();
  endtask

  task automatic drain();
    int n;
    rand_ready = 1'b0; fixed_ready = 1'b1; in_valid = 1'b0;
    n = 0;
    while ((q.size() != 0 || out_valid) && n < 50) begin
      tick();
      #2;
      n++;
    end
    check("drain_empty", 32'(q.size()), 32'd0);
  endtask

  // Monitor: a result seen with out_ready high is consumed on the next rising edge.
  always @(negedge clk) begin
    exp_t e;
    #2;
    if (rst_n && out_valid && out_ready) begin
      if (q.size() == 0) begin
        checks++; failures++;
        $display("FAIL unexpected_result actual=%h required=none", out_result);
      end else begin
        e = q.pop_front();
        check("sb_result", 32'(out_result), 32'(e.r));
        check("sb_cnt", 32'(out_cnt), 32'(e.c));
`ifdef SM_MAC_ZERO_SKIP_EN
        check("sb_skip", 32'(skip_cnt), 32'(e.s));
`endif
      end
    end
  end

  initial begin
    int len;
    rst_n = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; in_last = 1'b0; out_ready = 1'b1;
    #3;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_result", 32'(out_result), 32'd0);
    check("rst_out_cnt", 32'(out_cnt), 32'd0);
`ifdef SM_MAC_ZERO_SKIP_EN
    check("rst_skip_cnt", 32'(skip_cnt), 32'd0);
`endif
    tick();
    rst_n = 1'b1;
    tick();

    // Single negative beat: check latency, then the monitor checks the value.
    send(4'b0011, 4'b1010, 1'b1);
    check("lat_not_yet", 32'(out_valid), 32'd0);
    idle();
    check("lat_valid", 32'(out_valid), 32'd1);
    check("single_result", 32'(out_result), 32'h0000FFFA);
    drain();

    // Mixed-sign group of four.
    send(4'b0011, 4'b0010, 1'b0);
    send(4'b1011, 4'b0101, 1'b0);
    send(4'b0111, 4'b1111, 1'b0);
    send(4'b0111, 4'b0111, 1'b1);
    idle();
    drain();

    // Negative zero.
    send(4'b1000, 4'b1111, 1'b1);
    idle();
    drain();

    // Back-to-back single-beat groups.
    send(4'b0111, 4'b0111, 1'b1);
    send(4'b1001, 4'b0001, 1'b1);
    in_valid = 1'b0;
    check("b2b_first", 32'(out_result), 32'd49);
    tick();
    check("b2b_second_valid", 32'(out_valid), 32'd1);
    check("b2b_second", 32'(out_result), 32'h0000FFFF);
    drain();

    // Backpressure: hold the result, refuse the beat, then release.
    fixed_ready = 1'b0;
    tick();
    send(4'b0011, 4'b0010, 1'b1);
    idle();
    in_a = 4'b0001; in_b = 4'b0001; in_last = 1'b1; in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      check("bp_in_ready", 32'(in_ready), 32'd0);
      check("bp_out_valid", 32'(out_valid), 32'd1);
      check("bp_held_result", 32'(out_result), 32'd6);
      tick();
    end
    fixed_ready = 1'b1;
    tick();
    check("bp_release_ready", 32'(in_ready), 32'd1);
    model_accept(4'b0001, 4'b0001, 1'b1);
    tick();
    in_valid = 1'b0;
    check("bp_dropped", 32'(out_valid), 32'd0);
    tick();
    check("bp_new_valid", 32'(out_valid), 32'd1);
    drain();

    // Asynchronous reset mid-group discards the partial sum.
    send(4'b0111, 4'b0101, 1'b0);
    send(4'b1110, 4'b0011, 1'b0);
    in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_out_valid", 32'(out_valid), 32'd0);
    check("mid_rst_in_ready", 32'(in_ready), 32'd1);
    check("mid_rst_result", 32'(out_result), 32'd0);
    check("mid_rst_cnt", 32'(out_cnt), 32'd0);
    g_sum = 0; g_cnt = 0; g_skip = 0;
    tick();
    rst_n = 1'b1;
    tick();
    send(4'b0010, 4'b0011, 1'b1);
    idle();
    check("post_rst_result", 32'(out_result), 32'd6);
    drain();

    // Randomized groups under random backpressure and input gaps.
    rand_ready = 1'b1;
    for (int g = 0; g < 60; g++) begin
      len = $urandom_range(1, 6);
      for (int k = 0; k < len; k++) begin
        send(W'($urandom), W'($urandom), k == len - 1);
        if ($urandom_range(0, 3) == 0) idle();
      end
    end
    // A long group that wraps the beat counter is not needed; a long accumulation run is.
    for (int k = 0; k < 40; k++) send(4'b0111, 4'b1111, k == 39);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
